// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NWR_MAX   = 3;

  typedef struct packed {
    logic       hit;
    logic [1:0] port;
  } wsel_t;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // hits[p] = write port p targets the address of interest; highest index wins
  function automatic wsel_t write_select(input logic [NWR_MAX-1:0] hits);
    wsel_t s = '0;
    for (int unsigned i = 0; i < NWR_MAX; i++) begin
      if (hits[i]) begin
        s.hit  = 1'b1;
        s.port = 2'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bus between decode-issue, writeback and the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = clog2_f(NREGS);

  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD*XLEN-1:0] o_rs_data;
  logic [NRD-1:0]      o_rs_busy;
  logic [NWR*AW-1:0]   i_rd_addr;
  logic [NWR*XLEN-1:0] i_rd_data;
  logic [NWR-1:0]      i_rd_wren;
  logic                i_iss_valid;
  logic [AW-1:0]       i_iss_addr;
  logic                i_flush;
  logic [AW:0]         o_busy_cnt;

  modport master (
    output i_rs_addr, i_rd_addr, i_rd_data, i_rd_wren,
           i_iss_valid, i_iss_addr, i_flush,
    input  o_rs_data, o_rs_busy, o_busy_cnt
  );

  modport slave (
    input  i_rs_addr, i_rd_addr, i_rd_data, i_rd_wren,
           i_iss_valid, i_iss_addr, i_flush,
    output o_rs_data, o_rs_busy, o_busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection, with flush and a registered busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = clog2_f(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NWR*AW-1:0] i_rd_addr,
  input  logic [NWR-1:0]    i_rd_wren,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic              i_flush,
  output logic [NREGS-1:0]  o_busy,
  output logic [AW:0]       o_busy_cnt
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  // Issue is applied last so a new producer beats both a writeback clear and a flush.
  always_comb begin
    busy_d = busy_q;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (i_rd_wren[p]) busy_d[i_rd_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (i_iss_valid) busy_d[i_iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read bypass
// and a busy scoreboard for issue-time RAW hazard checks.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic         i_clk,
  input logic         i_rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = clog2_f(NREGS);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [AW-1:0]       wa    [NWR];
  logic [NREGS-1:0]    busy;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [AW-1:0]       ra;
  logic [NWR_MAX-1:0]  hits;
  wsel_t               sel;
  logic [XLEN-1:0]     rdata;
  logic                rbusy;

  always_comb begin
    for (int unsigned p = 0; p < NWR; p++) wa[p] = bus.i_rd_addr[p*AW +: AW];
  end

  // Ports are visited in ascending order, so the last nonblocking write (highest port) wins.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (bus.i_rd_wren[p] && wa[p] != '0) mem_q[wa[p]] <= bus.i_rd_data[p*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_addr   (bus.i_rd_addr),
    .i_rd_wren   (bus.i_rd_wren),
    .i_iss_valid (bus.i_iss_valid),
    .i_iss_addr  (bus.i_iss_addr),
    .i_flush     (bus.i_flush),
    .o_busy      (busy),
    .o_busy_cnt  (bus.o_busy_cnt)
  );

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    ra      = '0;
    hits    = '0;
    sel     = '0;
    rdata   = '0;
    rbusy   = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra   = bus.i_rs_addr[k*AW +: AW];
      hits = '0;
      for (int unsigned p = 0; p < NWR; p++) begin
        hits[p] = bus.i_rd_wren[p] && (wa[p] == ra) && (ra != '0);
      end
      sel   = write_select(hits);
      rdata = mem_q[ra];
      rbusy = busy[ra];
      if ((BYPASS != 0) && sel.hit) begin
        rdata = bus.i_rd_data[sel.port*XLEN +: XLEN];
        rbusy = 1'b0;
      end
      rs_data[k*XLEN +: XLEN] = rdata;
      rs_busy[k]              = rbusy;
    end
    // Bypass paths are combinational, so they are masked explicitly while reset is held.
    if (!i_rst) begin
      rs_data = '0;
      rs_busy = '0;
    end
  end

  assign bus.o_rs_data = rs_data;
  assign bus.o_rs_busy = rs_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 32-bit 2R/2W build and a non-bypassing 64-bit 4R/3W build
// share one stimulus stream and are checked every cycle against an array-based model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4*AW-1:0] rs_addr;
  logic [3*AW-1:0] rd_addr;
  logic [3*64-1:0] rd_data;
  logic [2:0]      rd_wren;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic            flush;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          cmp_en = 1'b0;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
  regfile_mp_if #(.XLEN(64), .NREGS(32), .NRD(4), .NWR(3)) bus_b ();

  assign bus_a.i_rs_addr   = rs_addr[2*AW-1:0];
  assign bus_a.i_rd_addr   = rd_addr[2*AW-1:0];
  assign bus_a.i_rd_data   = {rd_data[64 +: 32], rd_data[0 +: 32]};
  assign bus_a.i_rd_wren   = rd_wren[1:0];
  assign bus_a.i_iss_valid = iss_valid;
  assign bus_a.i_iss_addr  = iss_addr;
  assign bus_a.i_flush     = flush;

  assign bus_b.i_rs_addr   = rs_addr;
  assign bus_b.i_rd_addr   = rd_addr;
  assign bus_b.i_rd_data   = rd_data;
  assign bus_b.i_rd_wren   = rd_wren;
  assign bus_b.i_iss_valid = iss_valid;
  assign bus_b.i_iss_addr  = iss_addr;
  assign bus_b.i_flush     = flush;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_a)
  );

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(4), .NWR(3), .BYPASS(0)) dut_b (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_b)
  );

  logic [63:0] got_data [2][4];
  logic        got_busy [2][4];
  logic [5:0]  got_cnt  [2];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      got_data[0][k] = '0;
      got_busy[0][k] = 1'b0;
      got_data[1][k] = bus_b.o_rs_data[k*64 +: 64];
      got_busy[1][k] = bus_b.o_rs_busy[k];
    end
    for (int k = 0; k < 2; k++) begin
      got_data[0][k] = 64'(bus_a.o_rs_data[k*32 +: 32]);
      got_busy[0][k] = bus_a.o_rs_busy[k];
    end
    got_cnt[0] = bus_a.o_busy_cnt;
    got_cnt[1] = bus_b.o_busy_cnt;
  end

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];

  function automatic int nrd_of(int c);  return (c == 0) ? 2 : 4; endfunction
  function automatic int nwr_of(int c);  return (c == 0) ? 2 : 3; endfunction
  function automatic bit byp_of(int c);  return (c == 0);         endfunction
  function automatic logic [63:0] mask_of(int c);
    return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 32; r++) begin
          m_mem[c][r]  = '0;
          m_busy[c][r] = 1'b0;
        end
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < nwr_of(c); p++)
          if (rd_wren[p] && rd_addr[p*AW +: AW] != 0)
            m_mem[c][rd_addr[p*AW +: AW]] = rd_data[p*64 +: 64] & mask_of(c);
        if (flush) begin
          for (int r = 0; r < 32; r++) m_busy[c][r] = 1'b0;
        end else begin
          for (int p = 0; p < nwr_of(c); p++)
            if (rd_wren[p] && rd_addr[p*AW +: AW] != 0) m_busy[c][rd_addr[p*AW +: AW]] = 1'b0;
        end
        if (iss_valid && iss_addr != 0) m_busy[c][iss_addr] = 1'b1;
      end
    end
  end

  // {busy, data} a read of address a must return in config c
  function automatic logic [64:0] exp_read(int c, logic [AW-1:0] a);
    logic [63:0] d;
    bit          b;
    if (!rst_n || a == 0) return '0;
    d = m_mem[c][a];
    b = m_busy[c][a];
    if (byp_of(c))
      for (int p = 0; p < nwr_of(c); p++)
        if (rd_wren[p] && rd_addr[p*AW +: AW] == a) begin
          d = rd_data[p*64 +: 64] & mask_of(c);
          b = 1'b0;
        end
    return {b, d};
  endfunction

  function automatic int unsigned exp_cnt(int c);
    int unsigned n = 0;
    for (int r = 0; r < 32; r++) if (m_busy[c][r]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < nrd_of(c); k++) begin
          logic [64:0] e;
          e = exp_read(c, rs_addr[k*AW +: AW]);
          chk($sformatf("cfg%0d rs_data[%0d]", c, k), got_data[c][k], e[63:0]);
          chk($sformatf("cfg%0d rs_busy[%0d]", c, k), 64'(got_busy[c][k]), 64'(e[64]));
        end
        chk($sformatf("cfg%0d busy_cnt", c), 64'(got_cnt[c]), 64'(exp_cnt(c)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rd_wren   = '0;
    iss_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [63:0] d);
    rd_addr[p*AW +: AW] = a;
    rd_data[p*64 +: 64] = d;
    rd_wren[p]          = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    for (int k = 0; k < 4; k++) rs_addr[k*AW +: AW] = a;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    rs_addr  = '0;
    rd_addr  = '0;
    rd_data  = '0;
    iss_addr = '0;
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    step();
    rst_n = 1'b1;

    // every address reads zero and idle after reset
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a));
      #2;
      chk($sformatf("post-reset data x%0d a", a), got_data[0][1], 64'h0);
      chk($sformatf("post-reset data x%0d b", a), got_data[1][3], 64'h0);
      chk($sformatf("post-reset busy x%0d", a), 64'(got_busy[0][0]), 64'h0);
      step();
    end

    // write x5, then asynchronous reset mid-cycle, with a write in flight during reset
    idle(); wr(0, 5, 64'hDEAD_BEEF);
    step();
    idle(); rd(5);
    #2 chk("x5 written a", got_data[0][0], 64'hDEAD_BEEF);
    chk("x5 written b", got_data[1][0], 64'hDEAD_BEEF);
    rst_n = 1'b0;
    #1 chk("x5 async reset a", got_data[0][0], 64'h0);
    chk("x5 async reset b", got_data[1][2], 64'h0);
    wr(0, 5, 64'h1234);
    step();
    rst_n = 1'b1;
    idle();
    #2 chk("in-flight write discarded", got_data[0][0], 64'h0);

    // same-address writes: highest port wins; x0 ignores writes
    idle(); wr(0, 3, 64'h11); wr(1, 3, 64'h22);
    step();
    idle(); rd(3);
    #2 chk("x3 port priority a", got_data[0][0], 64'h22);
    chk("x3 port priority b", got_data[1][1], 64'h22);
    wr(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    idle(); rd(0);
    #2 chk("x0 reads zero a", got_data[0][0], 64'h0);
    chk("x0 reads zero b", got_data[1][0], 64'h0);

    // same-cycle write/read of x7
    idle(); rd(7); wr(0, 7, 64'hA5A5_A5A5);
    #2 chk("x7 bypass", got_data[0][0], 64'hA5A5_A5A5);
    chk("x7 no bypass old", got_data[1][0], 64'h0);
    step();
    idle();
    #2 chk("x7 no bypass next", got_data[1][0], 64'hA5A5_A5A5);

    // issue x9, write it back two cycles later
    idle(); iss(9);
    step();
    idle(); rd(9);
    #2 chk("x9 busy c1 a", 64'(got_busy[0][0]), 64'h1);
    chk("x9 busy c1 b", 64'(got_busy[1][0]), 64'h1);
    chk("cnt c1", 64'(got_cnt[0]), 64'h1);
    step();
    wr(0, 9, 64'h99);
    #2 chk("x9 busy bypassed clear", 64'(got_busy[0][0]), 64'h0);
    chk("x9 busy c2 b", 64'(got_busy[1][0]), 64'h1);
    chk("cnt c2", 64'(got_cnt[0]), 64'h1);
    step();
    idle();
    #2 chk("x9 idle a", 64'(got_busy[0][0]), 64'h0);
    chk("x9 idle b", 64'(got_busy[1][0]), 64'h0);
    chk("cnt c3 a", 64'(got_cnt[0]), 64'h0);
    chk("cnt c3 b", 64'(got_cnt[1]), 64'h0);

    // issue overrides a same-cycle writeback clear
    idle(); iss(4);
    step();
    wr(0, 4, 64'h44); iss(4);
    step();
    idle(); rd(4);
    #2 chk("x4 reissued a", 64'(got_busy[0][0]), 64'h1);
    chk("x4 reissued b", 64'(got_busy[1][0]), 64'h1);
    chk("x4 cnt", 64'(got_cnt[0]), 64'h1);
    iss(1); step();
    iss(2); step();
    iss(3); step();
    idle();
    #2 chk("cnt four busy", 64'(got_cnt[0]), 64'h4);

    // flush with a simultaneous issue leaves only the issued register busy
    flush = 1'b1; iss(6);
    step();
    idle(); rd(6);
    #2 chk("x6 busy after flush", 64'(got_busy[0][0]), 64'h1);
    chk("cnt after flush a", 64'(got_cnt[0]), 64'h1);
    chk("cnt after flush b", 64'(got_cnt[1]), 64'h1);
    rs_addr[1*AW +: AW] = 4;
    #1 chk("x4 flushed", 64'(got_busy[0][1]), 64'h0);
    step();

    // random traffic on both builds
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 4; k++) rs_addr[k*AW +: AW] = pick();
      for (int p = 0; p < 3; p++) begin
        rd_wren[p]          = ($urandom_range(0, 2) == 0);
        rd_addr[p*AW +: AW] = pick();
        rd_data[p*64 +: 64] = {$urandom, $urandom};
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = pick();
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end

    idle();
    step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
